// File: rtl/caesar_decrypt_engine.sv
// Caesar decryption engine: reads a ciphertext buffer word by word, subtracts the key and writes it back.
// Optional build macro CAESAR_ALPHA_WRAP_EN limits the shift to 'A'..'Z' with wraparound.
module caesar_decrypt_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [7:0]        key,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] char_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] base_q, len_q, idx_q, cnt_q;
  logic [7:0]        key_q;
  logic [DATA_W-1:0] plain_q, dec;
  logic              last;

  // index+1 evaluated one bit wider so len = 2^ADDR_W-1 cannot overflow the compare
  assign last = ({1'b0, idx_q} + (ADDR_W+1)'(1)) >= {1'b0, len_q};

`ifdef CAESAR_ALPHA_WRAP_EN
  logic [7:0] ch, kmod, off, rot;
  always_comb begin
    ch   = mem_rd_data[7:0];
    kmod = key_q % 8'd26;
    off  = ch - 8'd65;
    rot  = '0;
    dec  = mem_rd_data;
    if (mem_rd_data[DATA_W-1:8] == '0 && ch >= 8'd65 && ch <= 8'd90) begin
      rot = (off >= kmod) ? (off - kmod) : (off + 8'd26 - kmod);
      dec = DATA_W'(8'd65 + rot);
    end
  end
`else
  always_comb begin
    dec = mem_rd_data - DATA_W'(key_q);
  end
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      key_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      plain_q <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: if (start) begin
          base_q <= base_addr;
          len_q  <= len;
          key_q  <= key;
          idx_q  <= '0;
          cnt_q  <= '0;
        end
        S_CALC:  plain_q <= dec;
        S_WRITE: begin
          idx_q <= idx_q + ADDR_W'(1);
          cnt_q <= cnt_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = (len != '0) ? S_READ : S_DONE;
      S_READ:  nxt = S_CALC;
      S_CALC:  nxt = S_WRITE;
      S_WRITE: nxt = last ? S_DONE : S_READ;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Moore outputs: strobes come straight from state so reset kills them immediately
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign mem_rd_en   = (state == S_READ);
  assign mem_wr_en   = (state == S_WRITE);
  assign mem_addr    = (state == S_READ || state == S_WRITE) ? (base_q + idx_q) : '0;
  assign mem_wr_data = plain_q;
  assign char_count  = cnt_q;

endmodule

// File: doc/caesar_decrypt_engine.md
CAESAR_DECRYPT_ENGINE -- requirements
Module: caesar_decrypt_engine

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory data width; character held in bits [7:0].
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk1  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to decrypt a buffer; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first word address of ciphertext buffer; captured on accepted start.
REQ-008 len  input  ADDR_W  number of characters; captured on accepted start.
REQ-009 key  input  8  shift amount; captured on accepted start.
REQ-010 busy  output  1  high from the cycle after accepted start until DONE is exited.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 mem_addr  output  ADDR_W  memory address for read or write.
REQ-013 mem_rd_en  output  1  read strobe; data returns on mem_rd_data the next cycle.
REQ-014 mem_rd_data  input  DATA_W  read data, valid the cycle after mem_rd_en.
REQ-015 mem_wr_en  output  1  write strobe, one cycle, writes mem_wr_data to mem_addr.
REQ-016 mem_wr_data  output  DATA_W  decrypted word.
REQ-017 char_count  output  ADDR_W  characters written back since last accepted start.

Function
REQ-018 FSM states IDLE, READ, CALC, WRITE, DONE; exactly one active.
REQ-019 IDLE: start=1 -> capture base_addr/len/key, clear index and char_count; go READ if len!=0, else DONE.
REQ-020 READ: mem_addr=base+index, mem_rd_en=1 for one cycle -> CALC.
REQ-021 CALC: register plaintext computed from mem_rd_data -> WRITE.
REQ-022 WRITE: mem_addr=base+index, mem_wr_en=1, mem_wr_data=plaintext; increment index and char_count; -> READ if index+1<len, else DONE.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 Throughput: 3 cycles per character; done asserted 3*len+1 cycles after start is sampled (len=0: 1 cycle).
REQ-025 Address arithmetic base+index is modulo 2^ADDR_W (wraps past top of memory).
REQ-026 Default decryption: mem_wr_data = mem_rd_data - zero-extended key, modulo 2^DATA_W (exact inverse of the core's addi-based encryption).
REQ-027 start while not IDLE is ignored; captured parameters unchanged mid-operation.
REQ-028 mem_rd_en and mem_wr_en never both high; both low in IDLE, CALC, DONE.
REQ-029 busy low in IDLE; high in READ, CALC, WRITE, DONE.

Reset
REQ-030 rst_n low forces IDLE immediately, regardless of state, aborting any buffer in progress.
REQ-031 Reset values: busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, char_count=0, internal index/base/len/key=0.
REQ-032 A write in progress when reset asserts is not completed; no strobe is issued until a new start after reset release.

Configuration
REQ-033 Macro CAESAR_ALPHA_WRAP_EN: when defined, characters 65..90 ('A'..'Z') decrypt as 65 + ((c-65 - (key mod 26)) mod 26), result in 65..90; all other values, including bits above [7:0] nonzero, pass through unchanged.
REQ-034 Without CAESAR_ALPHA_WRAP_EN, REQ-026 applies to every word with no wrap logic synthesized.

Verification
REQ-035 mem[100..102]=68,69,70, base=100, len=3, key=3, start -> mem[100..102]=65,66,67, char_count=3, done pulse at cycle 10 after start.
REQ-036 len=0, start -> done one cycle later, no mem_rd_en/mem_wr_en ever asserted, char_count=0.
REQ-037 base=1023 (ADDR_W=10), len=2, mem[1023]=10, mem[0]=20, key=5 -> mem[1023]=5, mem[0]=15.
REQ-038 Second start pulsed in WRITE of first character of 3-char run -> ignored; exactly 3 writes, one done pulse.
REQ-039 rst_n pulsed low during CALC of second character -> busy=0 asynchronously, second write never issued, mem[101] unchanged.
REQ-040 With CAESAR_ALPHA_WRAP_EN: mem=65 ('A'), key=3 -> 88 ('X'); mem=48 ('0') -> 48; without macro mem=65,key=3 -> 62.
